// File: rtl/proc_issue_arbiter_if.sv
// Bus between the issue arbiter, its two instruction requesters and the shared processor.
// slave is the arbiter's view; master is the surrounding environment's view.
interface proc_issue_arbiter_if #(
    parameter int IW = 16
);
    logic          req0_valid;
    logic [IW-1:0] req0_instr;
    logic          req0_ready;
    logic          req1_valid;
    logic [IW-1:0] req1_instr;
    logic          req1_ready;
    logic [IW-1:0] proc_instr;
    logic          proc_run;
    logic          proc_done;
    logic          cmp_valid;
    logic          cmp_id;
    logic          cmp_timeout;

    modport slave (
        input  req0_valid, req0_instr, req1_valid, req1_instr, proc_done,
        output req0_ready, req1_ready, proc_instr, proc_run,
        output cmp_valid, cmp_id, cmp_timeout
    );

    modport master (
        output req0_valid, req0_instr, req1_valid, req1_instr, proc_done,
        input  req0_ready, req1_ready, proc_instr, proc_run,
        input  cmp_valid, cmp_id, cmp_timeout
    );
endinterface

// File: rtl/proc_issue_arbiter.sv
// Round-robin issue of two requesters' instructions to the shared mv/add/sub/mult processor,
// reporting a done-or-watchdog completion per instruction tagged with the owning requester.
module proc_issue_arbiter #(
    parameter int IW          = 16,
    parameter int TIMEOUT_CYC = 8     // legal 4..255
) (
    input  logic                clk,
    input  logic                reset,
    proc_issue_arbiter_if.slave bus,
    output logic                busy,
    output logic [7:0]          done_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    typedef struct packed {
        logic          id;
        logic [IW-1:0] instr;
    } hold_t;

    logic [1:0]         state;
    logic               prio;
    hold_t              hold;
    logic [7:0]         wait_cnt;
    logic [1:0]         req_valid;
    logic [1:0][IW-1:0] req_instr;
    logic [1:0]         grant;
    logic               gnt_id;
    logic               cmp_valid_q;
    logic               cmp_id_q;
    logic               cmp_timeout_q;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_instr = {bus.req1_instr, bus.req0_instr};

    // Grant is combinational in IDLE; held off during reset so every output reads 0 there.
    always_comb begin
        grant = '0;
        if (state == S_IDLE && reset) begin
            if (req_valid[prio])
                grant[prio] = 1'b1;
            else if (req_valid[~prio])
                grant[~prio] = 1'b1;
        end
    end

    assign gnt_id = grant[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            prio          <= 1'b0;
            hold          <= '0;
            wait_cnt      <= '0;
            cmp_valid_q   <= 1'b0;
            cmp_id_q      <= 1'b0;
            cmp_timeout_q <= 1'b0;
            done_cnt      <= '0;
        end else begin
            cmp_valid_q   <= 1'b0;
            cmp_id_q      <= 1'b0;
            cmp_timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        hold.instr <= req_instr[gnt_id];
                        hold.id    <= gnt_id;
                        prio       <= ~gnt_id;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes precedence over a watchdog expiring in the same cycle
                    if (bus.proc_done) begin
                        state       <= S_IDLE;
                        cmp_valid_q <= 1'b1;
                        cmp_id_q    <= hold.id;
                        done_cnt    <= done_cnt + 8'd1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state         <= S_IDLE;
                        cmp_valid_q   <= 1'b1;
                        cmp_id_q      <= hold.id;
                        cmp_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.proc_instr  = hold.instr;
    assign bus.proc_run    = (state == S_ISSUE);
    assign bus.cmp_valid   = cmp_valid_q;
    assign bus.cmp_id      = cmp_id_q;
    assign bus.cmp_timeout = cmp_timeout_q;
    assign busy            = (state != S_IDLE);
endmodule

// File: tb/tb_proc_issue_arbiter.sv
// Bench for proc_issue_arbiter: directed scenarios plus random traffic, checked each cycle
// against a transaction-latency reference model and a simple processor stand-in.
module tb_proc_issue_arbiter;
    localparam int IW  = 16;
    localparam int TMO = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [7:0] done_cnt;

    proc_issue_arbiter_if #(.IW(IW)) bus ();

    proc_issue_arbiter #(.IW(IW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // processor stand-in: done 1 cycle after run for mv, 3 for ALU ops, or d_ovr; never if hang
    int            pcnt;
    logic [IW-1:0] pinstr;
    logic [IW-1:0] regs [8];
    bit            hang;
    int            d_ovr;

    assign bus.proc_done = (pcnt == 1);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt   <= 0;
            pinstr <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (bus.proc_run) begin
                pinstr <= bus.proc_instr;
                pcnt   <= hang ? 0 : (d_ovr != 0) ? d_ovr :
                          (bus.proc_instr[15:13] == 3'b001) ? 1 : 3;
            end else if (pcnt != 0) begin
                pcnt <= pcnt - 1;
            end
            if (bus.proc_done) begin
                case (pinstr[15:13])
                    3'b001:  regs[pinstr[12:10]] <= {7'd0, pinstr[8:0]};
                    3'b011:  regs[pinstr[12:10]] <= regs[pinstr[12:10]] + {7'd0, pinstr[8:0]};
                    3'b010:  regs[pinstr[12:10]] <= regs[pinstr[12:10]] - {7'd0, pinstr[8:0]};
                    default: regs[pinstr[12:10]] <= regs[pinstr[12:10]] * {7'd0, pinstr[8:0]};
                endcase
            end
        end
    end

    // reference model state: time-stamped expectations, not an FSM
    int            n_pass, n_total;
    int            cyc, idle_at, cmp_at, last_acc, m_cnt, m_total;
    bit            m_prio, m_cmp_id, m_cmp_to;
    logic [IW-1:0] m_hold;
    int            gcount [2];
    int            obs_ids [$];
    int            obs_cmp_cyc;
    bit            obs_cmp_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [IW-1:0] rand_instr(input bit mv_only);
        logic [2:0] op;
        case (mv_only ? 0 : $urandom_range(0, 3))
            0:       op = 3'b001;
            1:       op = 3'b011;
            2:       op = 3'b010;
            default: op = 3'b100;
        endcase
        return {op, 3'($urandom), 1'b0, 9'($urandom)};
    endfunction

    task automatic model_clear();
        idle_at  = 0;
        cmp_at   = -1;
        last_acc = -10;
        m_cnt    = 0;
        m_total  = 0;
        m_prio   = 1'b0;
        m_hold   = '0;
    endtask

    // one clock cycle: drive at posedge+1, check at negedge, advance model
    task automatic tick(input bit v0, input logic [IW-1:0] i0, input bit v1, input logic [IW-1:0] i1);
        bit            v [2];
        logic [IW-1:0] ins [2];
        bit            idle;
        int            g, d, lat;
        v[0] = v0; v[1] = v1; ins[0] = i0; ins[1] = i1;
        bus.req0_valid = v0; bus.req0_instr = i0;
        bus.req1_valid = v1; bus.req1_instr = i1;
        @(negedge clk);
        idle = (cyc >= idle_at);
        if (cyc == cmp_at && !m_cmp_to) begin
            m_cnt = (m_cnt + 1) % 256;
            m_total++;
        end
        g = -1;
        if (idle) begin
            if (v[m_prio])       g = m_prio ? 1 : 0;
            else if (v[!m_prio]) g = m_prio ? 0 : 1;
        end
        chk("busy", busy, !idle);
        chk("rdy0", bus.req0_ready, g == 0);
        chk("rdy1", bus.req1_ready, g == 1);
        chk("run", bus.proc_run, cyc == last_acc + 1);
        chk("instr", bus.proc_instr, m_hold);
        chk("cmp_valid", bus.cmp_valid, cyc == cmp_at);
        if (cyc == cmp_at) begin
            chk("cmp_id", bus.cmp_id, m_cmp_id);
            chk("cmp_timeout", bus.cmp_timeout, m_cmp_to);
        end
        chk("done_cnt", done_cnt, m_cnt);
        if (bus.cmp_valid) begin
            obs_ids.push_back(int'(bus.cmp_id));
            obs_cmp_cyc = cyc;
            obs_cmp_to  = bus.cmp_timeout;
        end
        if (g >= 0) begin
            m_hold   = ins[g];
            m_prio   = (g == 0);
            last_acc = cyc;
            gcount[g]++;
            d = hang ? 1000 : (d_ovr != 0) ? d_ovr : (ins[g][15:13] == 3'b001) ? 1 : 3;
            m_cmp_to = (d > TMO);
            lat      = (d > TMO) ? TMO + 2 : d + 2;
            idle_at  = cyc + lat;
            cmp_at   = cyc + lat;
            m_cmp_id = (g == 1);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rdy0", bus.req0_ready, 0);
        chk("rst_rdy1", bus.req1_ready, 0);
        chk("rst_run", bus.proc_run, 0);
        chk("rst_cmpv", bus.cmp_valid, 0);
        chk("rst_cnt", done_cnt, 0);
        chk("rst_instr", bus.proc_instr, 0);
        @(posedge clk);
        #1;
        chk("rst_cmpv_hold", bus.cmp_valid, 0);
        reset = 1'b1;
        cyc++;
        model_clear();
    endtask

    initial begin
        int acc;
        bit s255;
        n_pass = 0; n_total = 0; cyc = 0;
        hang = 1'b0; d_ovr = 0;
        bus.req0_instr = '0; bus.req1_instr = '0;
        gcount[0] = 0; gcount[1] = 0;
        model_clear();
        #2;
        do_reset();

        // single mv from requester 0
        tick(1, 16'h2005, 0, '0);
        repeat (4) tick(0, '0, 0, '0);
        chk("mv_r0", regs[0], 16'h0005);

        // single add from requester 1
        tick(0, '0, 1, 16'h6003);
        repeat (6) tick(0, '0, 0, '0);
        chk("add_r0", regs[0], 16'h0008);

        // reset while waiting on the processor abandons the instruction
        tick(1, 16'h6001, 0, '0);
        repeat (2) tick(0, '0, 0, '0);
        chk("pre_rst_busy", busy, 1);
        do_reset();
        repeat (6) tick(0, '0, 0, '0);

        // round robin: both requesters valid until each has four grants
        gcount[0] = 0; gcount[1] = 0;
        obs_ids.delete();
        for (int k = 0; k < 60 && (gcount[0] < 4 || gcount[1] < 4); k++)
            tick(gcount[0] < 4, rand_instr(1), gcount[1] < 4, rand_instr(1));
        repeat (4) tick(0, '0, 0, '0);
        chk("rr_ncmp", obs_ids.size(), 8);
        foreach (obs_ids[k]) chk("rr_order", obs_ids[k], k % 2);
        chk("rr_cnt", done_cnt, 8);

        // watchdog: processor never answers
        hang = 1'b1;
        acc = cyc;
        tick(1, 16'h2007, 0, '0);
        repeat (TMO + 3) tick(0, '0, 0, '0);
        hang = 1'b0;
        chk("to_lat", obs_cmp_cyc - acc, TMO + 2);
        chk("to_flag", obs_cmp_to, 1);
        chk("to_cnt", done_cnt, 8);
        chk("to_idle", busy, 0);

        // done on the final wait cycle beats the watchdog
        d_ovr = TMO;
        acc = cyc;
        tick(0, '0, 1, 16'h6002);
        repeat (TMO + 3) tick(0, '0, 0, '0);
        d_ovr = 0;
        chk("race_lat", obs_cmp_cyc - acc, TMO + 2);
        chk("race_flag", obs_cmp_to, 0);
        chk("race_cnt", done_cnt, 9);

        // random traffic until the completion counter wraps
        do_reset();
        s255 = 1'b0;
        for (int k = 0; k < 8000 && m_total < 256; k++) begin
            tick($urandom_range(0, 3) != 0, rand_instr(0), $urandom_range(0, 3) != 0, rand_instr(0));
            if (m_total == 255 && !s255) begin
                s255 = 1'b1;
                chk("wrap_255", done_cnt, 255);
            end
        end
        chk("wrap_0", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
